// File: rtl/aes_dec_round.sv
// AES inverse-cipher round datapath: InvMixColumns -> InvShiftRows -> InvSubBytes,
// registered per stage, with an InvMixColumns bypass for the first inverse round.
module aes_dec_round #(
    parameter int unsigned SBOX_PIPE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         NextDec,
    input  logic [0:127] AddRoundKey_Out,
    input  logic [3:0]   Round,
    input  logic [3:0]   Nr,
    input  logic         DecFinish,
    output logic [0:127] InvMixColumns_Out,
    output logic [0:127] DecRound_Out,
    output logic         DecRoundValid,
    output logic         Busy
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 9/b/d/e multiples built from the x2/x4/x8 chain of each byte.
    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2;
        logic [7:0]   x4;
        logic [7:0]   x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[32*c+8*r +: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++) begin
                o[32*c+8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
            end
        end
        return o;
    endfunction

    // Row r rotates right by r: s'[r][c] = s[r][(c-r) mod 4].
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c+8*r +: 8] = s[32*((c-r+4)%4)+8*r +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
        end
        return o;
    endfunction

    logic [0:127] s1_q, s1_d;
    logic [0:127] s2_q, s2_d;
    logic [0:127] s3_q, s3_d;
    logic [0:127] out_q, out_d;
    logic         v1_q, v1_d;
    logic         v2_q, v2_d;
    logic         v3_q, v3_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         accept;

    assign accept = NextDec & ~busy_q & ~DecFinish;

    always_comb begin
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        out_d   = out_q;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        v3_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = busy_q;
        // A flush drops all in-flight work but leaves the data registers untouched.
        if (DecFinish) begin
            busy_d = 1'b0;
        end else begin
            if (accept) begin
                s1_d   = (Round == Nr) ? AddRoundKey_Out : inv_mix_columns(AddRoundKey_Out);
                v1_d   = 1'b1;
                busy_d = 1'b1;
            end
            if (v1_q) begin
                s2_d = inv_shift_rows(s1_q);
                v2_d = 1'b1;
            end
            if (SBOX_PIPE != 0) begin
                if (v2_q) begin
                    s3_d = inv_sub_bytes(s2_q);
                    v3_d = 1'b1;
                end
                if (v3_q) begin
                    out_d   = s3_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end else if (v2_q) begin
                out_d   = inv_sub_bytes(s2_q);
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            out_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            out_q   <= out_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign InvMixColumns_Out = s1_q;
    assign DecRound_Out      = out_q;
    assign DecRoundValid     = valid_q;
    assign Busy              = busy_q;

endmodule
